// File: rtl/dual_port_ram_pkg.sv
// Shared types for the dual-port RAM controller: clear-engine states and
// read-during-write mode encodings.
package dual_port_ram_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_e;

  localparam int RDW_MODE_OLD = 0;
  localparam int RDW_MODE_NEW = 1;

endpackage

// File: rtl/dual_port_ram_core.sv
// Pure storage array: one synchronous write port and one registered read port.
// Deliberately reset-free so synthesis can map it onto block RAM.
module dual_port_ram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read sees the pre-write content on an address collision (old-data RAM).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Dual-port RAM controller: clear engine, write-port mux, read-during-write
// bypass, optional output register and read-valid pipeline.
module dual_port_ram_ctrl
  import dual_port_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    OUTPUT_REG  = 0,
  parameter int                    RDW_NEW     = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  readEnable,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  input  logic                  clearRequest,
  output logic                  clearBusy
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_acc;
  logic                  rdw_hit;
  logic [DATA_WIDTH-1:0] core_rd_data;

  logic                  vld_p1_q, vld_p1_d;
  logic                  vld_p2_q, vld_p2_d;
  logic                  byp_p1_q, byp_p1_d;
  logic [DATA_WIDTH-1:0] byp_data_p1_q, byp_data_p1_d;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [DATA_WIDTH-1:0] data_p2_q, data_p2_d;
  logic                  seen_q, seen_d;
  logic                  out_vld_next;
  logic [DATA_WIDTH-1:0] out_data;

  // Clear FSM and write-port arbitration between external port and clear engine
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = writeAddress;
    mem_wdata  = dataIn;
    rd_acc     = 1'b0;
    case (state_q)
      IDLE: begin
        mem_we = writeEnable;
        rd_acc = readEnable;
        if (clearRequest) begin
          state_d    = CLEARING;
          clr_addr_d = '0;
        end
      end
      CLEARING: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = CLEAR_VALUE;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  dual_port_ram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk    (clock),
    .wr_en  (mem_we),
    .wr_addr(mem_waddr),
    .wr_data(mem_wdata),
    .rd_en  (rd_acc),
    .rd_addr(readAddress),
    .rd_data(core_rd_data)
  );

  // Stage p1: RAM read register plus the registered bypass select
  always_comb begin
    rdw_hit       = (RDW_NEW == RDW_MODE_NEW) && rd_acc && writeEnable &&
                    (writeAddress == readAddress);
    vld_p1_d      = rd_acc;
    byp_p1_d      = rd_acc ? rdw_hit : byp_p1_q;
    byp_data_p1_d = rd_acc ? dataIn : byp_data_p1_q;
    data_p1       = byp_p1_q ? byp_data_p1_q : core_rd_data;
  end

  // Stage p2: optional output register, loaded only when a new result arrives
  always_comb begin
    vld_p2_d     = vld_p1_q;
    data_p2_d    = vld_p1_q ? data_p1 : data_p2_q;
    out_vld_next = (OUTPUT_REG != 0) ? vld_p1_q : rd_acc;
    seen_d       = seen_q | out_vld_next;
    out_data     = (OUTPUT_REG != 0) ? data_p2_q : data_p1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      byp_p1_q   <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      byp_p1_q   <= byp_p1_d;
      seen_q     <= seen_d;
    end
  end

  always_ff @(posedge clock) begin
    byp_data_p1_q <= byp_data_p1_d;
    data_p2_q     <= data_p2_d;
  end

  // Data registers carry no reset; dataOut reads zero until the first result lands.
  assign dataOut   = seen_q ? out_data : '0;
  assign dataValid = (OUTPUT_REG != 0) ? vld_p2_q : vld_p1_q;
  assign clearBusy = (state_q == CLEARING);

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Randomised bench for dual_port_ram_ctrl: two configurations share stimulus and
// are compared every cycle against a behavioural memory/latency model.
module tb_dual_port_ram_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          writeEnable = 1'b0;
  logic [AW-1:0] writeAddress = '0;
  logic [DW-1:0] dataIn = '0;
  logic          readEnable = 1'b0;
  logic [AW-1:0] readAddress = '0;
  logic          clearRequest = 1'b0;

  logic [DW-1:0] dout0, dout1;
  logic          dv0, dv1, busy0, busy1;

  always #5 clock = ~clock;

  // u0: defaults with latency 1, old-data RDW.  u1: latency 2, new-data RDW.
  dual_port_ram_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(0), .RDW_NEW(0), .CLEAR_VALUE(8'hFF)
  ) u0 (
    .clock(clock), .reset(reset), .writeEnable(writeEnable), .writeAddress(writeAddress),
    .dataIn(dataIn), .readEnable(readEnable), .readAddress(readAddress),
    .dataOut(dout0), .dataValid(dv0), .clearRequest(clearRequest), .clearBusy(busy0)
  );

  dual_port_ram_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(1), .RDW_NEW(1), .CLEAR_VALUE(8'hFF)
  ) u1 (
    .clock(clock), .reset(reset), .writeEnable(writeEnable), .writeAddress(writeAddress),
    .dataIn(dataIn), .readEnable(readEnable), .readAddress(readAddress),
    .dataOut(dout1), .dataValid(dv1), .clearRequest(clearRequest), .clearBusy(busy1)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mdl_mem [DEPTH];
  rd_t           q0[$];
  rd_t           q1[$];
  logic [DW-1:0] last0, last1;
  int            busy_left;
  int            cyc;
  int            n_checks;
  int            n_fail;
  int            busy_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last0     = '0;
    last1     = '0;
    busy_left = 0;
  endtask

  task automatic check_outputs();
    logic exp_v0, exp_v1;
    exp_v0 = (q0.size() > 0) && (q0[0].due == cyc);
    exp_v1 = (q1.size() > 0) && (q1[0].due == cyc);
    if (exp_v0) begin last0 = q0[0].data; void'(q0.pop_front()); end
    if (exp_v1) begin last1 = q1[0].data; void'(q1.pop_front()); end
    check_eq("valid_lat1", 32'(dv0), 32'(exp_v0));
    check_eq("data_lat1", 32'(dout0), 32'(last0));
    check_eq("valid_lat2", 32'(dv1), 32'(exp_v1));
    check_eq("data_lat2", 32'(dout1), 32'(last1));
    check_eq("busy_lat1", 32'(busy0), 32'(busy_left > 0));
    check_eq("busy_lat2", 32'(busy1), 32'(busy_left > 0));
  endtask

  // One clock cycle: drive, let the edge happen, apply the rules to the model, compare.
  task automatic tick(input logic we, input int wa, input logic [DW-1:0] wd,
                      input logic re, input int ra, input logic cr);
    rd_t e;
    logic [DW-1:0] old;
    @(negedge clock);
    writeEnable  = we;
    writeAddress = AW'(wa);
    dataIn       = wd;
    readEnable   = re;
    readAddress  = AW'(ra);
    clearRequest = cr;
    @(posedge clock);
    cyc++;
    if (busy_left > 0) begin
      mdl_mem[DEPTH - busy_left] = 8'hFF;
      busy_left--;
    end else begin
      if (re) begin
        old    = mdl_mem[ra];
        e.due  = cyc;
        e.data = old;
        q0.push_back(e);
        e.due  = cyc + 1;
        e.data = (we && (wa == ra)) ? wd : old;
        q1.push_back(e);
      end
      if (we) mdl_mem[wa] = wd;
      if (cr) busy_left = DEPTH;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic rand_ops(input int n, input int base, input int span);
    for (int i = 0; i < n; i++)
      tick(1'($urandom), base + int'($urandom % span), 8'($urandom),
           1'($urandom), base + int'($urandom % span), 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    model_reset();

    #2 reset = 1'b1;
    #1;
    check_eq("rst_dout0", 32'(dout0), 0);
    check_eq("rst_dv0", 32'(dv0), 0);
    check_eq("rst_busy0", 32'(busy0), 0);
    check_eq("rst_dout1", 32'(dout1), 0);
    check_eq("rst_dv1", 32'(dv1), 0);
    check_eq("rst_busy1", 32'(busy1), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Preload addr -> addr
    for (int a = 0; a < DEPTH; a++) tick(1'b1, a, 8'(a), 1'b0, 0, 1'b0);

    // Write then read on the next cycle
    tick(1'b1, 'h010, 8'hA5, 1'b0, 0, 1'b0);
    tick(1'b0, 0, '0, 1'b1, 'h010, 1'b0);
    check_eq("wr_rd_lat1", 32'(dout0), 32'hA5);
    tick(1'b0, 0, '0, 1'b0, 0, 1'b0);
    check_eq("wr_rd_lat2", 32'(dout1), 32'hA5);
    idle(2);

    // Same-address read-during-write
    tick(1'b1, 'h020, 8'h11, 1'b0, 0, 1'b0);
    tick(1'b1, 'h020, 8'h3C, 1'b1, 'h020, 1'b0);
    check_eq("rdw_old", 32'(dout0), 32'h11);
    tick(1'b0, 0, '0, 1'b0, 0, 1'b0);
    check_eq("rdw_new", 32'(dout1), 32'h3C);
    tick(1'b0, 0, '0, 1'b1, 'h020, 1'b0);
    idle(3);

    // Streaming reads
    for (int i = 0; i < 16; i++) tick(1'b0, 0, '0, 1'b1, i, 1'b0);
    idle(3);

    rand_ops(400, 0, 16);
    idle(2);

    // Clear with a same-cycle write and read, then hammer the ports while busy
    busy_cnt = 0;
    tick(1'b1, 'h030, 8'h77, 1'b1, 'h030, 1'b1);
    if (busy0) busy_cnt++;
    for (int k = 0; k < 4100; k++) begin
      if (k == 10)      tick(1'b1, 'h100, 8'h55, 1'b1, 'h100, 1'b0);
      else if (k == 20) tick(1'b0, 0, '0, 1'b1, 5, 1'b1);
      else              tick(1'($urandom), 'h200 + int'($urandom % 16), 8'($urandom),
                             1'($urandom), 'h200 + int'($urandom % 16), 1'b0);
      if (busy0) busy_cnt++;
    end
    check_eq("busy_cycles", 32'(busy_cnt), DEPTH);
    idle(1);
    tick(1'b0, 0, '0, 1'b1, 'h000, 1'b0);
    check_eq("clr_000", 32'(dout0), 32'hFF);
    tick(1'b0, 0, '0, 1'b1, 'h7FF, 1'b0);
    check_eq("clr_7ff", 32'(dout0), 32'hFF);
    tick(1'b0, 0, '0, 1'b1, 'hFFF, 1'b0);
    check_eq("clr_fff", 32'(dout0), 32'hFF);
    tick(1'b0, 0, '0, 1'b1, 'h100, 1'b0);
    check_eq("clr_drop_100", 32'(dout0), 32'hFF);
    idle(2);

    // Distinct stale values around the abort point, then abort a clear at cycle 100
    for (int a = 'h060; a < 'h070; a++) tick(1'b1, a, 8'(a + 1), 1'b0, 0, 1'b0);
    tick(1'b0, 0, '0, 1'b0, 0, 1'b1);
    idle(100);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("abort_busy0", 32'(busy0), 0);
    check_eq("abort_dv0", 32'(dv0), 0);
    check_eq("abort_busy1", 32'(busy1), 0);
    check_eq("abort_dv1", 32'(dv1), 0);
    check_eq("abort_dout1", 32'(dout1), 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick(1'b0, 0, '0, 1'b1, 'h063, 1'b0);
    check_eq("abort_063", 32'(dout0), 32'hFF);
    tick(1'b0, 0, '0, 1'b1, 'h064, 1'b0);
    check_eq("abort_064", 32'(dout0), 32'h65);
    for (int a = 'h060; a < 'h070; a++) tick(1'b0, 0, '0, 1'b1, a, 1'b0);
    idle(3);

    rand_ops(200, 'h060, 32);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
